// File: rtl/load_align_unit.sv
// Load return path: tracks issued loads through the fixed-latency memory read, aligns and
// extends the returned data, and skid-buffers returns across writeback stalls.
// Optional feature macro: LOAD_MISALIGN_TRAP_EN (suppress misaligned LH/LHU/LW, raise misalign).
module load_align_unit #(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned DEST_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [2:0]        ld_ctrl,
    input  logic [31:0]       ld_addr,
    input  logic [DEST_W-1:0] ld_dest,
    input  logic              stall,
    input  logic              flush,
    input  logic [31:0]       imem_dout,
    input  logic [31:0]       dmem_dout,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [DEST_W-1:0] wb_dest,
    output logic              busy,
    output logic              misalign
);
    localparam int unsigned PTR_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {SRC_ZERO, SRC_IMEM, SRC_DMEM} src_e;

    typedef struct packed {
        logic [2:0]        ctrl;
        logic [1:0]        off;
        src_e              src;
        logic [DEST_W-1:0] dest;
    } tag_t;

    typedef struct packed {
        logic [31:0]       data;
        logic [DEST_W-1:0] dest;
        logic              mis;
    } res_t;

    logic              tag_vld_q [LATENCY];
    logic              tag_vld_d [LATENCY];
    tag_t              tag_q     [LATENCY];
    tag_t              tag_d     [LATENCY];
    res_t              skid_q    [LATENCY];
    res_t              skid_d    [LATENCY];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_vld_q, out_vld_d, out_mis_q, out_mis_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [DEST_W-1:0] out_dest_q, out_dest_d;

    logic        accept, skid_empty, pipe_busy, push, pop, load_en;
    src_e        new_src;
    tag_t        arr_tag;
    logic        arr_vld, arr_mis;
    logic [31:0] arr_word, arr_data;
    logic [7:0]  arr_byte;
    logic [15:0] arr_half;
    res_t        arr_res, load_res;
    logic        addr_unused;

    assign addr_unused = ^{ld_addr[30], ld_addr[27:2]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LATENCY - 1)) ? '0 : p + 1'b1;
    endfunction

    assign skid_empty = (cnt_q == '0);
    assign accept     = ld_valid & skid_empty & ~stall & ~flush & (ld_ctrl <= 3'b100);

    always_comb begin
        if (~ld_addr[31] & ld_addr[28])      new_src = SRC_DMEM;
        else if (~ld_addr[31] & ld_addr[29]) new_src = SRC_IMEM;
        else                                 new_src = SRC_ZERO;
    end

    // The oldest tag meets its memory word in the same cycle.
    always_comb begin
        arr_vld = tag_vld_q[LATENCY-1];
        arr_tag = tag_q[LATENCY-1];
        case (arr_tag.src)
            SRC_DMEM: arr_word = dmem_dout;
            SRC_IMEM: arr_word = imem_dout;
            default:  arr_word = '0;
        endcase
        case (arr_tag.off)
            2'd0:    arr_byte = arr_word[31:24];
            2'd1:    arr_byte = arr_word[23:16];
            2'd2:    arr_byte = arr_word[15:8];
            default: arr_byte = arr_word[7:0];
        endcase
        arr_half = arr_tag.off[1] ? arr_word[15:0] : arr_word[31:16];
        case (arr_tag.ctrl)
            3'b000:  arr_data = {{24{arr_byte[7]}}, arr_byte};
            3'b001:  arr_data = {{16{arr_half[15]}}, arr_half};
            3'b011:  arr_data = {24'b0, arr_byte};
            3'b100:  arr_data = {16'b0, arr_half};
            default: arr_data = arr_word;
        endcase
        arr_mis = 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
        case (arr_tag.ctrl)
            3'b001, 3'b100: arr_mis = arr_tag.off[0];
            3'b010:         arr_mis = |arr_tag.off;
            default:        arr_mis = 1'b0;
        endcase
`endif
        arr_res.data = arr_mis ? '0 : arr_data;
        arr_res.dest = arr_tag.dest;
        arr_res.mis  = arr_mis;
    end

    always_comb begin
        tag_vld_d[0]  = accept;
        tag_d[0].ctrl = ld_ctrl;
        tag_d[0].off  = ld_addr[1:0];
        tag_d[0].src  = new_src;
        tag_d[0].dest = ld_dest;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_d[i]     = tag_q[i-1];
        end
        if (flush) begin
            for (int unsigned i = 0; i < LATENCY; i++) tag_vld_d[i] = 1'b0;
        end
    end

    // Skid head always drains before the current arrival, preserving issue order.
    always_comb begin
        skid_d     = skid_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        out_vld_d  = out_vld_q;
        out_mis_d  = out_mis_q;
        out_data_d = out_data_q;
        out_dest_d = out_dest_q;
        push       = 1'b0;
        pop        = 1'b0;
        load_en    = 1'b0;
        load_res   = arr_res;
        if (flush) begin
            cnt_d     = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            out_vld_d = 1'b0;
            out_mis_d = 1'b0;
        end else begin
            if (~stall) begin
                if (!skid_empty) begin
                    load_en  = 1'b1;
                    load_res = skid_q[rd_ptr_q];
                    pop      = 1'b1;
                    push     = arr_vld;
                end else if (arr_vld) begin
                    load_en = 1'b1;
                end else begin
                    out_vld_d = 1'b0;
                    out_mis_d = 1'b0;
                end
            end else if (arr_vld) begin
                if (skid_empty & ~out_vld_q & ~out_mis_q) load_en = 1'b1;
                else                                      push    = 1'b1;
            end
            if (load_en) begin
                out_vld_d  = ~load_res.mis;
                out_mis_d  = load_res.mis;
                out_data_d = load_res.data;
                out_dest_d = load_res.dest;
            end
            if (push) begin
                skid_d[wr_ptr_q] = arr_res;
                wr_ptr_d         = ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_q[i]     <= '0;
                skid_q[i]    <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_mis_q  <= 1'b0;
            out_data_q <= '0;
            out_dest_q <= '0;
        end else begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_d[i];
                tag_q[i]     <= tag_d[i];
                skid_q[i]    <= skid_d[i];
            end
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            out_vld_q  <= out_vld_d;
            out_mis_q  <= out_mis_d;
            out_data_q <= out_data_d;
            out_dest_q <= out_dest_d;
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int unsigned i = 0; i < LATENCY; i++) pipe_busy = pipe_busy | tag_vld_q[i];
    end

    assign ld_ready = skid_empty;
    assign wb_valid = out_vld_q;
    assign wb_data  = out_data_q;
    assign wb_dest  = out_dest_q;
    assign misalign = out_mis_q;
    assign busy     = pipe_busy | ~skid_empty | out_vld_q | out_mis_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: directed cases plus random traffic against a queue-based
// reference model of issue, memory return, stall buffering and flush.
module tb_load_align_unit;
    localparam int unsigned LAT  = 2;
    localparam int unsigned DW   = 5;
    localparam int          MAXC = 2048;

    logic          clk, rst_n, ld_valid, ld_ready, stall, flush;
    logic          wb_valid, busy, misalign;
    logic [2:0]    ld_ctrl;
    logic [31:0]   ld_addr, imem_dout, dmem_dout, wb_data;
    logic [DW-1:0] ld_dest, wb_dest;

    load_align_unit #(.LATENCY(LAT), .DEST_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_ctrl(ld_ctrl), .ld_addr(ld_addr), .ld_dest(ld_dest), .stall(stall),
        .flush(flush), .imem_dout(imem_dout), .dmem_dout(dmem_dout),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest), .busy(busy),
        .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic          mis;
        logic [31:0]   data;
        logic [DW-1:0] dest;
    } ent_t;

    ent_t          infl[$];
    ent_t          pend[$];
    logic          exp_vld, exp_mis;
    logic [31:0]   exp_data;
    logic [DW-1:0] exp_dest;
    logic [31:0]   drv_i [MAXC];
    logic [31:0]   drv_d [MAXC];
    int            cyc, total, bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic void ref_load(input logic [2:0] ctrl, input logic [31:0] addr,
                                     input logic [31:0] iw, input logic [31:0] dw,
                                     output logic mis, output logic [31:0] data);
        logic [31:0] w;
        int unsigned off, b, h;
        if (addr[31] == 1'b0 && addr[28] == 1'b1)      w = dw;
        else if (addr[31] == 1'b0 && addr[29] == 1'b1) w = iw;
        else                                           w = 32'h0;
        off = addr % 4;
        b   = (w >> (8 * (3 - off))) % 256;
        h   = (addr[1] == 1'b1) ? w % 65536 : w / 65536;
        case (ctrl)
            3'd0:    data = (b > 127) ? b + 32'hFFFF_FF00 : b;
            3'd1:    data = (h > 32767) ? h + 32'hFFFF_0000 : h;
            3'd3:    data = b;
            3'd4:    data = h;
            default: data = w;
        endcase
        mis = 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
        mis = ((ctrl == 3'd1 || ctrl == 3'd4) && (off % 2 == 1)) || (ctrl == 3'd2 && off != 0);
`endif
    endfunction

    task automatic set_out(input ent_t a);
        exp_vld  = !a.mis;
        exp_mis  = a.mis;
        exp_data = a.data;
        exp_dest = a.dest;
    endtask

    task automatic do_cycle(input logic v, input logic [2:0] ctrl, input logic [31:0] addr,
                            input logic [DW-1:0] dest, input logic st, input logic fl);
        ent_t e, a;
        logic acc, arr_ok;
        chk("ld_ready", 32'(ld_ready), 32'(pend.size() == 0));
        chk("busy", 32'(busy), 32'(infl.size() != 0 || pend.size() != 0 || exp_vld || exp_mis));
        chk("wb_valid", 32'(wb_valid), 32'(exp_vld));
        chk("misalign", 32'(misalign), 32'(exp_mis));
        if (exp_vld || exp_mis) chk("wb_dest", 32'(wb_dest), 32'(exp_dest));
        if (exp_vld) chk("wb_data", wb_data, exp_data);

        ld_valid  = v;
        ld_ctrl   = ctrl;
        ld_addr   = addr;
        ld_dest   = dest;
        stall     = st;
        flush     = fl;
        imem_dout = drv_i[cyc];
        dmem_dout = drv_d[cyc];

        acc    = v && pend.size() == 0 && !st && !fl && ctrl <= 3'd4;
        arr_ok = infl.size() != 0 && infl[0].cyc + int'(LAT) == cyc;
        if (fl) begin
            infl.delete();
            pend.delete();
            exp_vld = 1'b0;
            exp_mis = 1'b0;
        end else begin
            if (arr_ok) a = infl.pop_front();
            if (!st) begin
                if (arr_ok) pend.push_back(a);
                if (pend.size() != 0) set_out(pend.pop_front());
                else begin
                    exp_vld = 1'b0;
                    exp_mis = 1'b0;
                end
            end else if (arr_ok) begin
                if (!exp_vld && !exp_mis && pend.size() == 0) set_out(a);
                else pend.push_back(a);
            end
        end
        if (acc) begin
            e.cyc  = cyc;
            e.dest = dest;
            ref_load(ctrl, addr, drv_i[cyc+LAT], drv_d[cyc+LAT], e.mis, e.data);
            infl.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        do_cycle(1'b0, 3'd0, 32'h0, '0, 1'b0, 1'b0);
    endtask

    task automatic ld(input logic [2:0] ctrl, input logic [31:0] addr, input logic [DW-1:0] dest,
                      input logic [31:0] dw, input logic [31:0] iw);
        drv_d[cyc+LAT] = dw;
        drv_i[cyc+LAT] = iw;
        do_cycle(1'b1, ctrl, addr, dest, 1'b0, 1'b0);
    endtask

    task automatic expect_after(input string tag, input logic [31:0] expv);
        repeat (LAT) idle();
        chk({tag, "_valid"}, 32'(wb_valid), 32'd1);
        chk(tag, wb_data, expv);
    endtask

    initial begin
        logic          v, st, fl;
        logic [2:0]    rc;
        logic [3:0]    nib;
        logic [31:0]   ra;
        logic [3:0]    nibs [6];
        total = 0;
        bad   = 0;
        cyc   = 0;
        nibs  = '{4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'h4};
        for (int i = 0; i < MAXC; i++) begin
            drv_i[i] = $urandom;
            drv_d[i] = $urandom;
        end
        exp_vld = 1'b0; exp_mis = 1'b0; exp_data = '0; exp_dest = '0;
        rst_n = 1'b0; ld_valid = 1'b0; ld_ctrl = '0; ld_addr = '0; ld_dest = '0;
        stall = 1'b0; flush = 1'b0; imem_dout = '0; dmem_dout = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_wb_valid", 32'(wb_valid), 32'd0);
        chk("reset_wb_data", wb_data, 32'h0);
        chk("reset_wb_dest", 32'(wb_dest), 32'd0);
        chk("reset_misalign", 32'(misalign), 32'd0);
        chk("reset_ld_ready", 32'(ld_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        ld(3'd0, 32'h1000_0003, 5'd3, 32'h8899_AABB, $urandom);
        expect_after("lb_sext", 32'hFFFF_FFBB);
        ld(3'd3, 32'h1000_0001, 5'd4, 32'h8899_AABB, $urandom);
        expect_after("lbu_zext", 32'h0000_0099);
        ld(3'd1, 32'h1000_0002, 5'd5, 32'h1234_ABCD, $urandom);
        expect_after("lh_sext", 32'hFFFF_ABCD);
        ld(3'd4, 32'h1000_0002, 5'd6, 32'h1234_ABCD, $urandom);
        expect_after("lhu_zext", 32'h0000_ABCD);
        ld(3'd2, 32'h2000_0004, 5'd7, $urandom, 32'hDEAD_BEEF);
        expect_after("lw_imem", 32'hDEAD_BEEF);
        ld(3'd2, 32'h8000_0000, 5'd8, 32'h1357_9BDF, 32'h2468_ACE0);
        expect_after("lw_zero_region", 32'h0000_0000);
        ld(3'd2, 32'h3000_0000, 5'd9, 32'h1111_1111, 32'h2222_2222);
        expect_after("lw_dmem_priority", 32'h1111_1111);
`ifdef LOAD_MISALIGN_TRAP_EN
        ld(3'd2, 32'h1000_0002, 5'd10, 32'hCAFE_F00D, $urandom);
        repeat (LAT) idle();
        chk("mis_flag", 32'(misalign), 32'd1);
        chk("mis_valid", 32'(wb_valid), 32'd0);
        chk("mis_dest", 32'(wb_dest), 32'd10);
`else
        ld(3'd2, 32'h1000_0002, 5'd10, 32'hCAFE_F00D, $urandom);
        expect_after("lw_unaligned_full", 32'hCAFE_F00D);
`endif
        ld(3'd5, 32'h1000_0000, 5'd11, $urandom, $urandom);
        repeat (LAT) idle();
        chk("store_ctrl_ignored", 32'(wb_valid), 32'd0);
        idle();

        for (int i = 0; i <= int'(LAT) + 8; i++) begin
            if (i >= int'(LAT) + 1 && i <= int'(LAT) + 4) begin
                chk("stall_hold_valid", 32'(wb_valid), 32'd1);
                chk("stall_hold_dest", 32'(wb_dest), 32'd1);
            end
            if (i == int'(LAT) + 2) chk("stall_ready_low", 32'(ld_ready), 32'd0);
            if (i == int'(LAT) + 5) chk("stall_drain_reg2", 32'(wb_dest), 32'd2);
            if (i == int'(LAT) + 6) chk("stall_drain_reg3", 32'(wb_dest), 32'd3);
            do_cycle(i < 3, 3'd2, 32'h1000_0010 + 32'(4 * i), DW'(i + 1),
                     i >= int'(LAT) + 1 && i <= int'(LAT) + 3, 1'b0);
        end

        for (int i = 0; i <= int'(LAT) + 5; i++) begin
            if (i >= 1) chk("flush_no_valid", 32'(wb_valid), 32'd0);
            if (i == 4) chk("flush_busy_clear", 32'(busy), 32'd0);
            do_cycle(i < 2, 3'd2, 32'h1000_0020 + 32'(4 * i), DW'(i + 12), 1'b0, i == 2);
        end

        for (int n = 0; n < 500; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            rc  = 3'($urandom_range(0, 7));
            nib = nibs[$urandom_range(0, 5)];
            ra  = {nib, 28'($urandom)};
            st  = ($urandom_range(0, 9) < 3);
            fl  = ($urandom_range(0, 39) == 0);
            do_cycle(v, rc, ra, DW'($urandom), st, fl);
        end
        repeat (LAT + 4) idle();

        for (int k = 0; k < 3; k++) ld(3'd2, 32'h1000_0000 + 32'(4 * k), DW'(20 + k), $urandom, $urandom);
        rst_n = 1'b0; ld_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        #1;
        chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
        chk("midrst_wb_data", wb_data, 32'h0);
        chk("midrst_wb_dest", 32'(wb_dest), 32'd0);
        chk("midrst_misalign", 32'(misalign), 32'd0);
        chk("midrst_ld_ready", 32'(ld_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        infl.delete();
        pend.delete();
        exp_vld = 1'b0; exp_mis = 1'b0; exp_data = '0; exp_dest = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        repeat (LAT + 3) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_align_unit.md
# load_align_unit

- Read-side counterpart of the store address/byte-lane logic; sits at the MEM/WB boundary of the MIPS pipeline.
- Tracks each issued load through the fixed-latency imem/dmem read.
- Selects the returned word by address region, then extracts the addressed byte or halfword (big-endian lane order) with sign or zero extension.
- Presents the result with its destination register to writeback, and buffers in-flight returns across pipeline stalls.

## Interface
Parameters:
- LATENCY, 1, memory read latency in cycles (1..3); data for a request issued in cycle T is on *_dout during cycle T+LATENCY.
- DEST_W, 5, destination register index width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld_valid  in  1  load issue request (MEM stage).
- ld_ready  out  1  issue permitted; equals skid buffer empty.
- ld_ctrl  in  3  LdStCtrl: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU; 101/110/111 are stores, never accepted as loads.
- ld_addr  in  32  effective address (ALU output).
- ld_dest  in  DEST_W  destination register.
- stall  in  1  writeback hold.
- flush  in  1  kill all in-flight loads.
- imem_dout  in  32  imem read word.
- dmem_dout  in  32  dmem read word.
- wb_valid  out  1  result valid.
- wb_data  out  32  aligned, extended result.
- wb_dest  out  DEST_W  destination of result.
- busy  out  1  any load in pipe, skid or un-consumed output.
- misalign  out  1  misaligned-load flag; present in both builds.

## Operation
- Accept: ld_valid & ld_ready & ~stall & ~flush & ld_ctrl<=100. Capture ctrl, addr[1:0], source select and dest into a LATENCY-deep tag pipe; the pipe advances every cycle regardless of stall.
- Source select uses the address region bits:
  - ~addr[31] & addr[28] selects dmem (dmem wins when addr[29] is also set).
  - else ~addr[31] & addr[29] selects imem.
  - otherwise the word is 32'h0.
- Lane extraction, with w as the selected word and off as addr[1:0]:
  - LB/LBU: byte w[31-8*off -: 8].
  - LH/LHU: off[1]=0 gives w[31:16]; off[1]=1 gives w[15:0].
  - LW: w unchanged.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Each arriving tag+word goes to the output register when it is free or being consumed (~stall), else it is pushed into the skid FIFO (depth LATENCY). This is a FIFO, not a shift register.
- While the skid is non-empty, the output register loads from the skid head (oldest first), and new arrivals queue behind.
- The output is consumed on any cycle with ~stall; if nothing is pending, wb_valid drops.
- ld_ready=0 whenever the skid is non-empty. This bounds outstanding loads so the skid never overflows.
- flush (priority over everything) clears tag pipe valids, skid and wb_valid at the next edge. Memory words still returning for flushed tags are discarded.

## Timing
- Reset values: wb_valid 0, wb_data 0, wb_dest 0, misalign 0, ld_ready 1, busy 0. All state clears asynchronously.
- Latency: accept in T → wb_valid/wb_data/wb_dest registered and visible in cycle T+LATENCY+1 when not stalled.
- Throughput: 1 load/cycle sustained while stall=0.
- Stall: wb_* hold stable while stall=1. Up to LATENCY arrivals are buffered and emerge one per cycle, in issue order, starting the cycle after stall falls.
- Reset or flush mid-operation: no stale wb_valid afterwards.
- A simultaneous push and pop on the skid is legal and keeps occupancy constant.

## Configuration
- LOAD_MISALIGN_TRAP_EN defined:
  - LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, is misaligned.
  - That result's slot produces wb_valid=0 and misalign=1, with wb_dest set to its destination.
  - misalign holds under stall, like wb_valid.
- Undefined:
  - misalign is tied 0.
  - LH uses addr[1] only; LW ignores addr[1:0].
  - No load is suppressed.

## Test plan
- LATENCY=1, LB at 0x1000_0003, dmem_dout=0x8899AABB → wb_data 0xFFFFFFBB, wb_valid in T+2; LBU at 0x1000_0001 → 0x00000099.
- LH/LHU at 0x1000_0002, dmem_dout=0x1234ABCD → 0xFFFFABCD / 0x0000ABCD; LW at 0x2000_0004, imem_dout=0xDEADBEEF → 0xDEADBEEF; LW at 0x8000_0000 → 0x00000000.
- LATENCY=2:
  - Stimulus: loads to regs 1,2,3 in consecutive cycles, stall high 3 cycles starting when reg1's result appears.
  - Required: reg1 held throughout the stall; then reg2, reg3 on consecutive cycles; ld_ready low while the skid is non-empty.
- Flush one cycle after two issued loads → wb_valid never asserts for either; busy 0 two cycles later.
- With LOAD_MISALIGN_TRAP_EN: LW at 0x1000_0002 → misalign=1, wb_valid=0 in T+LATENCY+1. Without it: same load returns the full dmem word.
- Assert rst_n low while three loads are in flight → all outputs at reset values immediately, ld_ready 1.
